vector_result_writer: RTL

VECTOR_RESULT_WRITER -- requirements
Module: vector_result_writer

---
 rtl/vector_result_writer_pkg.sv | 22 ++
 rtl/vector_result_writer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vector_result_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vector_result_writer_pkg
// Brief   : Shared state encoding and lane geometry for vector_result_writer.
// Rev     : 1.0
// ============================================================================
package vector_result_writer_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int lane_count(input int n);
        return n / LANE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_result_writer.sv
`default_nettype none
// ============================================================================
// Module  : vector_result_writer
// Brief   : Captures a lo/hi result vector pair and streams it out as 32-bit
//           word writes to consecutive addresses.
// Rev     : 1.0
// ============================================================================
module vector_result_writer
    import vector_result_writer_pkg::*;
#(
    parameter int N      = 512,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hi_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [N-1:0]      result_lo,
    input  logic [N-1:0]      result_hi,
    output logic              busy,
    output logic              done,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata
);

    localparam int L  = lane_count(N);
    localparam int KW = (2 * L > 1) ? $clog2(2 * L) : 1;
    localparam logic [KW-1:0] LAST_HI = KW'(2 * L - 1);
    localparam logic [KW-1:0] LAST_LO = KW'(L - 1);

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [N-1:0]        lo_q, lo_d;
    logic [N-1:0]        hi_q, hi_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                hi_en_q, hi_en_d;
    logic                mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [2*N-1:0]      cat_d;
    logic [KW-1:0]       last_k;

    assign last_k = hi_en_q ? LAST_HI : LAST_LO;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        base_d  = base_q;
        hi_en_d = hi_en_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lo_d    = result_lo;
                    hi_d    = result_hi;
                    base_d  = base_addr;
                    hi_en_d = hi_en;
                    k_d     = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    if (k_q == last_k) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are computed from next-state values so they can be flopped
        // and still line up with the state they describe.
        cat_d       = {hi_d, lo_d};
        mem_wdata_d = cat_d[int'(k_d) * LANE_W +: LANE_W];
        mem_addr_d  = base_d + ADDR_W'(k_d);
        mem_valid_d = (state_d == ST_WRITE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            base_q      <= '0;
            hi_en_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            base_q      <= base_d;
            hi_en_q     <= hi_en_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire
